ddr3_local_if_responder: RTL and testbench
==========================================

# ddr3_local_if_responder

Synthesizable responder for the DDR3 core local user interface (cmd/cmd_rdy/datain_rdy/read_data handshake). It stands in for the DDR3 controller and PHY during bring-up and simulation. Our traffic generators and exercise state machines connect to it unchanged. Commands are accepted with the same pulse/window protocol as the real core, and write data is stored in an on-chip RAM so it can be read back.

## Interface
Parameters:
- MEM_AW, 8: beat-address width; the RAM holds 2^MEM_AW 64-bit beats.
- INIT_CYCLES, 16: cycles after reset before the first cmd_rdy pulse (models calibration).
- WR_LATENCY, 2: cycles from command accept to the datain_rdy pulse (≥1).
- RD_LATENCY, 4: cycles from command accept to the first read_data_valid (≥2).
- MISC_BUSY, 8: busy cycles for LOAD_MR/ZQ/refresh commands.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-high.
- cmd_valid, in, 1: command strobe.
- cmd, in, 4: command code (NADA 0, READ 1, WRITE 2, READA 3, WRITEA 4, PDOWN_ENT 5, LOAD_MR 6, SEL_REF_ENT 8, SEL_REF_EXIT 9, PDOWN_EXIT 11, ZQ_LNG 12, ZQ_SHRT 13).
- cmd_burst_cnt, in, 5: burst count; 0 means 32.
- addr, in, 26: beat address; only addr[MEM_AW-1:0] is used.
- write_data, in, 64: write beat.
- data_mask, in, 8: per-byte mask; bit i = 1 means byte i is not written.
- cmd_rdy, out, 1: one-cycle pulse that opens a command window.
- datain_rdy, out, 1: one-cycle pulse that precedes the write beats.
- read_data, out, 64: read beat; 0 when not valid.
- read_data_valid, out, 1: read beat strobe.
- wl_err, out, 1: write-leveling error; constant 0.
- init_done, out, 1: high from the first cmd_rdy pulse onward.
- proto_err, out, 1: sticky protocol error; cleared only by rst.

## Operation
- Beats per command: N = 2 × cmd_burst_cnt (range 2..64). Beat k uses RAM index (addr + k) mod 2^MEM_AW, so bursts wrap.
- FSM states and transitions:
  - INIT counts INIT_CYCLES, then goes to OFFER.
  - OFFER: cmd_rdy = 1 for one cycle, then WINDOW.
  - WINDOW: if cmd_valid = 0, return to OFFER. If cmd_valid = 1, the command is accepted and decoded:
    - WRITE/WRITEA → WR_WAIT.
    - READ/READA → RD_WAIT.
    - PDOWN_ENT sets pd; PDOWN_EXIT clears pd; both → OFFER.
    - LOAD_MR, ZQ_*, SEL_REF_* → BUSY.
    - NADA or an undefined code → proto_err, then OFFER.
  - WR_WAIT: after WR_LATENCY cycles, datain_rdy = 1 for one cycle, then WR_DATA.
  - WR_DATA: samples write_data/data_mask on N consecutive cycles. The first beat is the cycle after the datain_rdy pulse. Then OFFER.
  - RD_WAIT, then RD_DATA: read_data_valid high for N consecutive cycles. The first beat comes RD_LATENCY cycles after the accept cycle. Then OFFER.
  - BUSY: MISC_BUSY cycles, then OFFER.
- cmd_valid = 1 in any state other than WINDOW is ignored and sets proto_err.
- READ or WRITE accepted while pd = 1: set proto_err, no data phase, return to OFFER.
- READA/WRITEA behave exactly like READ/WRITE; auto-precharge has no effect in this model.
- cmd_burst_cnt and addr are captured at accept; later input changes do not affect the command in flight.
- RAM contents are not cleared by rst; they are undefined until written.

## Timing
- Reset value of every output is 0: cmd_rdy, datain_rdy, read_data, read_data_valid, wl_err, init_done, proto_err.
- First cmd_rdy pulse: cycle INIT_CYCLES after rst deasserts; init_done rises in that same cycle.
- When idle, cmd_rdy pulses every second cycle (OFFER/WINDOW alternate).
- Write: accept at cycle A → datain_rdy at A+WR_LATENCY → beats at A+WR_LATENCY+1 … A+WR_LATENCY+N.
- Read: the RAM is synchronous with 1-cycle read latency; address issue starts at A+RD_LATENCY-1 and beats appear at A+RD_LATENCY … A+RD_LATENCY+N-1.
- Next OFFER: the cycle after the last beat.
- rst mid-burst: all outputs clear immediately and the FSM returns to INIT. A partial write leaves the already-written beats in RAM.

## Structure
- Package ddr3_if_pkg holds the command-code constants, the field widths (CMD_W 4, ADDR_W 26, DATA_W 64, MASK_W 8, BCNT_W 5) and the FSM state enum.
- Sub-module ddr3_resp_mem: single-port synchronous RAM, 64-bit, 8 byte-enables, 1-cycle read.
- The top level holds the FSM, the latency/beat counters and the address incrementer.

## Test plan
- rst, then idle: first cmd_rdy exactly 16 cycles after rst release; init_done = 1 from that cycle; pulses every 2 cycles; proto_err = 0.
- WRITE addr 0x0001400, bcnt 1, beats 0x1AAA2AAA3AAA4AAA and 0xE555D555C555B555, then READ 0x0001400 → the same two beats, read_data_valid 2 cycles starting at accept+4.
- Masked write: mask 0x0F, data all-ones over prior 0 → read returns 0xFFFFFFFF00000000.
- Wrap: WRITE addr 0xFF, bcnt 1, MEM_AW = 8 → beats stored at indices 0xFF and 0x00, confirmed by readback.
- cmd_valid pulsed in an OFFER cycle → proto_err = 1 and stays 1. Separately, PDOWN_ENT then READ → proto_err = 1 and no read_data_valid.
- rst asserted on the 2nd read beat → read_data_valid = 0 the same cycle; next cmd_rdy comes 16 cycles after release.

Source files
------------

// File: rtl/ddr3_if_pkg.sv
// Shared constants for the DDR3 local-interface responder: command codes,
// local-interface field widths, FSM state encoding and a burst-length helper.
package ddr3_if_pkg;

  localparam int CMD_W  = 4;
  localparam int ADDR_W = 26;
  localparam int DATA_W = 64;
  localparam int MASK_W = 8;
  localparam int BCNT_W = 5;

  // Command codes as driven by the traffic generators
  localparam logic [CMD_W-1:0] CMD_NADA         = 4'd0;
  localparam logic [CMD_W-1:0] CMD_READ         = 4'd1;
  localparam logic [CMD_W-1:0] CMD_WRITE        = 4'd2;
  localparam logic [CMD_W-1:0] CMD_READA        = 4'd3;
  localparam logic [CMD_W-1:0] CMD_WRITEA       = 4'd4;
  localparam logic [CMD_W-1:0] CMD_PDOWN_ENT    = 4'd5;
  localparam logic [CMD_W-1:0] CMD_LOAD_MR      = 4'd6;
  localparam logic [CMD_W-1:0] CMD_SEL_REF_ENT  = 4'd8;
  localparam logic [CMD_W-1:0] CMD_SEL_REF_EXIT = 4'd9;
  localparam logic [CMD_W-1:0] CMD_PDOWN_EXIT   = 4'd11;
  localparam logic [CMD_W-1:0] CMD_ZQ_LNG       = 4'd12;
  localparam logic [CMD_W-1:0] CMD_ZQ_SHRT      = 4'd13;

  // FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_INIT    = 3'd0;
  localparam state_t ST_OFFER   = 3'd1;
  localparam state_t ST_WINDOW  = 3'd2;
  localparam state_t ST_WR_WAIT = 3'd3;
  localparam state_t ST_WR_DATA = 3'd4;
  localparam state_t ST_RD_WAIT = 3'd5;
  localparam state_t ST_RD_DATA = 3'd6;
  localparam state_t ST_BUSY    = 3'd7;

  // Beats per command: two per burst count, with a count of 0 meaning 32
  function automatic logic [6:0] burst_beats(input logic [BCNT_W-1:0] bcnt);
    return (bcnt == '0) ? 7'd64 : {1'b0, bcnt, 1'b0};
  endfunction

endpackage

// File: rtl/ddr3_resp_mem.sv
// Single-port synchronous beat RAM with per-byte write enables and a
// registered read. Each byte lane is its own array so synthesis maps it
// onto byte-write block RAM. Contents are never reset.
module ddr3_resp_mem #(
  parameter int AW = 8,
  parameter int BW = 8
) (
  input  logic            clk,
  input  logic [AW-1:0]   addr_i,
  input  logic            we_i,
  input  logic [BW-1:0]   be_i,
  input  logic [BW*8-1:0] wdata_i,
  output logic [BW*8-1:0] rdata_o
);

  localparam int DEPTH = 2 ** AW;

  for (genvar gi = 0; gi < BW; gi++) begin : g_lane
    logic [7:0] lane_q [DEPTH];
    logic [7:0] rd_q;

    // Byte-lane write when enabled, read of the same address every cycle
    always_ff @(posedge clk) begin
      if (we_i && be_i[gi]) begin
        lane_q[addr_i] <= wdata_i[gi*8 +: 8];
      end
      rd_q <= lane_q[addr_i];
    end

    assign rdata_o[gi*8 +: 8] = rd_q;
  end

endmodule

// File: rtl/ddr3_local_if_responder.sv
// Stand-in for the DDR3 controller + PHY local interface. Offers command
// windows with cmd_rdy pulses, runs write/read data phases against an
// on-chip beat RAM and flags protocol violations in a sticky proto_err.
module ddr3_local_if_responder
  import ddr3_if_pkg::*;
#(
  parameter int MEM_AW      = 8,
  parameter int INIT_CYCLES = 16,
  parameter int WR_LATENCY  = 2,
  parameter int RD_LATENCY  = 4,
  parameter int MISC_BUSY   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [CMD_W-1:0]  cmd,
  input  logic [BCNT_W-1:0] cmd_burst_cnt,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [MASK_W-1:0] data_mask,
  output logic              cmd_rdy,
  output logic              datain_rdy,
  output logic [DATA_W-1:0] read_data,
  output logic              read_data_valid,
  output logic              wl_err,
  output logic              init_done,
  output logic              proto_err
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WR_LATENCY - 1);
  // The read wait ends one cycle early so the RAM address is issued in time
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_LATENCY - 2);
  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(MISC_BUSY - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [6:0]         beat_q, beat_d;
  logic [6:0]         nbeats_q, nbeats_d;
  logic [MEM_AW-1:0]  base_q, base_d;
  logic               pd_q, pd_d;
  logic               proto_err_q, proto_err_d;
  logic               init_done_q, init_done_d;

  logic [6:0]         beat_off;
  logic [MEM_AW-1:0]  mem_addr;
  logic               mem_we;
  logic [DATA_W-1:0]  mem_rdata;

  // Only the low MEM_AW address bits select a RAM beat
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[ADDR_W-1:MEM_AW];

  // Next-state logic: command window decode, latency and beat counting
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    beat_d      = beat_q;
    nbeats_d    = nbeats_q;
    base_d      = base_q;
    pd_d        = pd_q;
    proto_err_d = proto_err_q;
    init_done_d = init_done_q;

    case (state_q)
      ST_INIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d     = ST_OFFER;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_OFFER: state_d = ST_WINDOW;

      ST_WINDOW: begin
        state_d = ST_OFFER;
        if (cmd_valid) begin
          base_d   = addr[MEM_AW-1:0];
          nbeats_d = burst_beats(cmd_burst_cnt);
          cnt_d    = '0;
          beat_d   = '0;
          case (cmd)
            CMD_READ, CMD_READA: begin
              if (pd_q) proto_err_d = 1'b1;
              else      state_d     = ST_RD_WAIT;
            end
            CMD_WRITE, CMD_WRITEA: begin
              if (pd_q) proto_err_d = 1'b1;
              else      state_d     = ST_WR_WAIT;
            end
            CMD_PDOWN_ENT:  pd_d = 1'b1;
            CMD_PDOWN_EXIT: pd_d = 1'b0;
            CMD_LOAD_MR, CMD_ZQ_LNG, CMD_ZQ_SHRT,
            CMD_SEL_REF_ENT, CMD_SEL_REF_EXIT: state_d = ST_BUSY;
            default: proto_err_d = 1'b1;
          endcase
        end
      end

      ST_WR_WAIT: begin
        if (cnt_q == WR_LAST) begin
          state_d = ST_WR_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WR_DATA: begin
        if (beat_q == nbeats_q - 7'd1) state_d = ST_OFFER;
        else                           beat_d  = beat_q + 7'd1;
      end

      ST_RD_WAIT: begin
        if (cnt_q == RD_LAST) begin
          state_d = ST_RD_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RD_DATA: begin
        if (beat_q == nbeats_q - 7'd1) state_d = ST_OFFER;
        else                           beat_d  = beat_q + 7'd1;
      end

      ST_BUSY: begin
        if (cnt_q == BUSY_LAST) begin
          state_d = ST_OFFER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase

    // A strobe outside the command window is a protocol violation
    if (cmd_valid && (state_q != ST_WINDOW)) proto_err_d = 1'b1;
  end

  // State registers; reset returns to calibration and clears every output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      beat_q      <= '0;
      nbeats_q    <= '0;
      base_q      <= '0;
      pd_q        <= 1'b0;
      proto_err_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      nbeats_q    <= nbeats_d;
      base_q      <= base_d;
      pd_q        <= pd_d;
      proto_err_q <= proto_err_d;
      init_done_q <= init_done_d;
    end
  end

  // RAM address: current beat when writing, one beat ahead when reading
  // (the RAM output is registered), burst base otherwise
  always_comb begin
    beat_off = '0;
    if (state_q == ST_WR_DATA)      beat_off = beat_q;
    else if (state_q == ST_RD_DATA) beat_off = beat_q + 7'd1;
  end

  assign mem_addr = base_q + MEM_AW'(beat_off);
  assign mem_we   = (state_q == ST_WR_DATA);

  ddr3_resp_mem #(
    .AW (MEM_AW),
    .BW (MASK_W)
  ) u_mem (
    .clk     (clk),
    .addr_i  (mem_addr),
    .we_i    (mem_we),
    .be_i    (~data_mask),
    .wdata_i (write_data),
    .rdata_o (mem_rdata)
  );

  assign cmd_rdy         = (state_q == ST_OFFER);
  assign datain_rdy      = (state_q == ST_WR_WAIT) && (cnt_q == WR_LAST);
  assign read_data_valid = (state_q == ST_RD_DATA);
  assign read_data       = read_data_valid ? mem_rdata : '0;
  assign wl_err          = 1'b0;
  assign init_done       = init_done_q;
  assign proto_err       = proto_err_q;

endmodule

// File: tb/tb_ddr3_local_if_responder.sv
// Randomized scoreboard bench for ddr3_local_if_responder. The driver pushes
// expected read beats (data + cycle) from a plain-array memory model; a
// separate monitor pops and compares whenever read_data_valid is seen.
module tb_ddr3_local_if_responder;
  import ddr3_if_pkg::*;

  localparam int WRL  = 2;
  localparam int RDL  = 4;
  localparam int BUSY = 8;
  localparam int INIT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [3:0]  cmd = '0;
  logic [4:0]  cmd_burst_cnt = '0;
  logic [25:0] addr = '0;
  logic [63:0] write_data = '0;
  logic [7:0]  data_mask = '0;
  logic        cmd_rdy, datain_rdy, read_data_valid, wl_err, init_done, proto_err;
  logic [63:0] read_data;

  ddr3_local_if_responder #(
    .MEM_AW(8), .INIT_CYCLES(INIT), .WR_LATENCY(WRL), .RD_LATENCY(RDL), .MISC_BUSY(BUSY)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_burst_cnt(cmd_burst_cnt),
    .addr(addr), .write_data(write_data), .data_mask(data_mask), .cmd_rdy(cmd_rdy),
    .datain_rdy(datain_rdy), .read_data(read_data), .read_data_valid(read_data_valid),
    .wl_err(wl_err), .init_done(init_done), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [63:0] data; int at; } exp_t;
  exp_t        rdq[$];
  exp_t        mon_e;
  logic [63:0] model_mem [256];
  logic [63:0] wbuf [64];
  logic [7:0]  mbuf [64];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_offer = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic summary_and_finish();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  task automatic abort(input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out, required event never occurred (cycle %0d)", what, cyc);
    summary_and_finish();
  endtask

  function automatic int nb(input logic [4:0] bc);
    return (bc == 0) ? 64 : 2 * int'(bc);
  endfunction

  // Monitor: every read beat must match the head of the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && read_data_valid) begin
        n_tests++;
        if (rdq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rdv: read_data_valid=1 at cycle %0d, required 0", cyc);
        end else begin
          mon_e = rdq.pop_front();
          if (read_data !== mon_e.data || cyc != mon_e.at) begin
            n_fail++;
            $display("FAIL rd_beat: got %h at cycle %0d, required %h at cycle %0d",
                     read_data, cyc, mon_e.data, mon_e.at);
          end
        end
      end else if (!rst) begin
        n_tests++;
        if (read_data !== 64'h0) begin
          n_fail++;
          $display("FAIL rd_idle_zero: got %h, required 0 (cycle %0d)", read_data, cyc);
        end
      end
    end
  end

  initial begin
    #800000;
    abort("watchdog");
  end

  task automatic wait_rdy();
    int k = 0;
    while (cmd_rdy !== 1'b1) begin
      @(posedge clk); #1;
      k++;
      if (k > 400) abort("cmd_rdy_wait");
    end
    if (exp_offer >= 0) check("next_offer_cycle", 64'(cyc), 64'(exp_offer));
    exp_offer = -1;
  endtask

  task automatic issue(input logic [3:0] c, input logic [4:0] bc, input logic [25:0] a,
                       output int acc);
    wait_rdy();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd = c; cmd_burst_cnt = bc; addr = a;
    acc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd = 4'($urandom); cmd_burst_cnt = 5'($urandom); addr = 26'($urandom);
  endtask

  task automatic do_write(input logic [3:0] c, input logic [4:0] bc, input logic [25:0] a);
    int acc, n, k, idx;
    issue(c, bc, a, acc);
    n = nb(bc);
    k = 0;
    while (datain_rdy !== 1'b1) begin
      @(posedge clk); #1;
      k++;
      if (k > 50) abort("datain_rdy_wait");
    end
    check("datain_rdy_cycle", 64'(cyc), 64'(acc + WRL));
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      write_data = wbuf[i];
      data_mask  = mbuf[i];
      idx = (int'(a[7:0]) + i) % 256;
      for (int b = 0; b < 8; b++)
        if (!mbuf[i][b]) model_mem[idx][8*b +: 8] = wbuf[i][8*b +: 8];
    end
    @(posedge clk); #1;
    write_data = {$urandom, $urandom};
    data_mask  = 8'($urandom);
    exp_offer  = acc + WRL + n + 1;
    $display("[TB] WRITE cmd=%0d addr=%h beats=%0d accepted at cycle %0d", c, a, n, acc);
  endtask

  task automatic do_read(input logic [3:0] c, input logic [4:0] bc, input logic [25:0] a,
                         output int acc);
    int n;
    exp_t e;
    issue(c, bc, a, acc);
    n = nb(bc);
    for (int i = 0; i < n; i++) begin
      e.data = model_mem[(int'(a[7:0]) + i) % 256];
      e.at   = acc + RDL + i;
      rdq.push_back(e);
    end
    exp_offer = acc + RDL + n;
    $display("[TB] READ cmd=%0d addr=%h beats=%0d accepted at cycle %0d", c, a, n, acc);
  endtask

  task automatic do_misc(input logic [3:0] c);
    int acc;
    issue(c, 5'd0, 26'd0, acc);
    exp_offer = acc + BUSY + 1;
    $display("[TB] MISC cmd=%0d accepted at cycle %0d", c, acc);
  endtask

  // Release reset after an edge and check the calibration delay and idle pattern
  task automatic release_and_check();
    int k = 0;
    rdq.delete();
    exp_offer = -1;
    rst = 1'b0;
    while (cmd_rdy !== 1'b1 && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (k == INIT - 1) check("init_done_before_first_rdy", 64'(init_done), 64'd0);
    end
    check("first_cmd_rdy_delay", 64'(k), 64'(INIT));
    check("init_done_at_first_rdy", 64'(init_done), 64'd1);
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk); #1;
      check("idle_rdy_pattern", 64'(cmd_rdy), 64'((j % 2) == 0));
    end
    check("proto_err_after_reset", 64'(proto_err), 64'd0);
    $display("[TB] reset released, first cmd_rdy after %0d cycles", k);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({cmd_rdy, datain_rdy, read_data_valid, wl_err, init_done, proto_err}), 64'd0);
    check("reset_read_data", read_data, 64'd0);
    release_and_check();
  endtask

  task automatic drain();
    int k = 0;
    while (rdq.size() != 0) begin
      @(posedge clk); #1;
      k++;
      if (k > 200) abort("read_drain");
    end
  endtask

  initial begin
    int acc, op, k, cnt;
    logic [4:0] bc;
    logic [25:0] a;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({cmd_rdy, datain_rdy, read_data_valid, wl_err, init_done, proto_err}), 64'd0);
    check("reset_read_data", read_data, 64'd0);
    release_and_check();

    // Fill the whole RAM so every later read has a defined expectation
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 64; i++) begin wbuf[i] = {$urandom, $urandom}; mbuf[i] = 8'h00; end
      do_write(CMD_WRITE, 5'd0, 26'(blk * 64));
    end

    // Directed two-beat write and readback
    wbuf[0] = 64'h1AAA2AAA3AAA4AAA; wbuf[1] = 64'hE555D555C555B555;
    mbuf[0] = 8'h00; mbuf[1] = 8'h00;
    do_write(CMD_WRITE, 5'd1, 26'h0001400);
    do_read(CMD_READ, 5'd1, 26'h0001400, acc);

    // Masked write: all-ones over zero with the low four bytes masked
    wbuf[0] = 64'h0; wbuf[1] = 64'h0; mbuf[0] = 8'h00; mbuf[1] = 8'h00;
    do_write(CMD_WRITE, 5'd1, 26'h10);
    wbuf[0] = '1; wbuf[1] = '1; mbuf[0] = 8'h0F; mbuf[1] = 8'h0F;
    do_write(CMD_WRITEA, 5'd1, 26'h10);
    do_read(CMD_READA, 5'd1, 26'h10, acc);

    // Wrap at the top of the beat address space
    wbuf[0] = {$urandom, $urandom}; wbuf[1] = {$urandom, $urandom};
    mbuf[0] = 8'h00; mbuf[1] = 8'h00;
    do_write(CMD_WRITE, 5'd1, 26'h00000FF);
    do_read(CMD_READ, 5'd1, 26'h00000FF, acc);
    do_read(CMD_READ, 5'd1, 26'h0000000, acc);

    // Randomized traffic mix
    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(0, 9);
      bc = 5'($urandom);
      a  = 26'($urandom);
      if (op < 4) begin
        for (int i = 0; i < 64; i++) begin
          wbuf[i] = {$urandom, $urandom};
          mbuf[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
        end
        do_write((op[0]) ? CMD_WRITEA : CMD_WRITE, bc, a);
      end else if (op < 8) begin
        do_read((op[0]) ? CMD_READA : CMD_READ, bc, a, acc);
      end else begin
        case ($urandom_range(0, 4))
          0: do_misc(CMD_LOAD_MR);
          1: do_misc(CMD_ZQ_LNG);
          2: do_misc(CMD_ZQ_SHRT);
          3: do_misc(CMD_SEL_REF_ENT);
          default: do_misc(CMD_SEL_REF_EXIT);
        endcase
      end
    end
    wait_rdy();
    drain();
    check("proto_err_clean_traffic", 64'(proto_err), 64'd0);

    // cmd_valid during an OFFER cycle is a violation and sticks
    wait_rdy();
    cmd_valid = 1'b1; cmd = CMD_READ; cmd_burst_cnt = 5'd1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("proto_err_offer_strobe", 64'(proto_err), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    check("proto_err_sticky", 64'(proto_err), 64'd1);
    $display("[TB] OFFER-cycle strobe: proto_err=%0d", proto_err);

    apply_reset();

    // Power-down then READ: violation, no data phase
    issue(CMD_PDOWN_ENT, 5'd0, 26'd0, acc);
    exp_offer = acc + 1;
    issue(CMD_READ, 5'd1, 26'h20, acc);
    exp_offer = acc + 1;
    check("proto_err_pd_read", 64'(proto_err), 64'd1);
    wait_rdy();
    cnt = 0;
    for (int j = 0; j < RDL + 4; j++) begin
      if (read_data_valid === 1'b1) cnt++;
      @(posedge clk); #1;
    end
    check("pd_read_no_rdv", 64'(cnt), 64'd0);
    $display("[TB] PDOWN_ENT + READ at cycle %0d: proto_err=%0d rdv_count=%0d", acc, proto_err, cnt);
    issue(CMD_PDOWN_EXIT, 5'd0, 26'd0, acc);
    exp_offer = acc + 1;
    do_read(CMD_READ, 5'd1, 26'h20, acc);
    wait_rdy();
    drain();

    // Reset on the second beat of a read
    do_read(CMD_READ, 5'd1, 26'h40, acc);
    k = 0;
    while (cyc < acc + RDL + 1) begin
      @(posedge clk); #1;
      k++;
      if (k > 50) abort("midburst_wait");
    end
    rst = 1'b1;
    #1;
    check("midburst_rst_rdv", 64'(read_data_valid), 64'd0);
    check("midburst_rst_rdata", read_data, 64'd0);
    check("midburst_rst_init_done", 64'(init_done), 64'd0);
    check("midburst_first_beat_seen", 64'(rdq.size()), 64'd1);
    $display("[TB] reset asserted on second read beat at cycle %0d", cyc);
    repeat (2) @(posedge clk);
    #1;
    release_and_check();

    // RAM contents survive reset
    do_read(CMD_READ, 5'd1, 26'h40, acc);
    wait_rdy();
    drain();

    summary_and_finish();
  end

endmodule
